// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring unsigned divide behind a start/done handshake.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;      // multiplicand (MUL) / dividend-quotient shifter (DIV)
    logic [WIDTH-1:0] r_b;      // multiplier (MUL) / divisor (DIV)
    logic [WIDTH-1:0] r_acc;    // partial product (MUL) / partial remainder (DIV)
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_accept = start_i && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_single = '0;
        case (ALUCtrl_i)
            3'b000:  w_single = data1_i & data2_i;
            3'b001:  w_single = data1_i | data2_i;
            3'b010:  w_single = data1_i + data2_i;
            3'b011:  w_single = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            3'b110:  w_single = data1_i - data2_i;
            3'b111:  w_single = data1_i;
            default: w_single = '0;
        endcase
    end

    assign w_mul_next = r_acc + (r_b[0] ? r_a : '0);

    // A zero divisor never borrows, so every quotient bit comes out 1.
    assign w_shift    = {r_acc, r_a[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_a[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_zero  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= data1_i;
                        r_b   <= data2_i;
                        r_acc <= '0;
                        r_cnt <= '0;
                        case (ALUCtrl_i)
                            3'b100: r_state <= S_MUL;
                            3'b101: r_state <= S_DIV;
                            default: begin
                                r_data <= w_single;
                                r_zero <= (w_single == '0);
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_data  <= w_mul_next;
                        r_zero  <= (w_mul_next == '0);
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_rem_next;
                    r_a   <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_data  <= w_quo_next;
                        r_zero  <= (w_quo_next == '0);
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_o = r_data;
    assign Zero_o = r_zero;
    assign done_o = r_done;
    assign busy_o = (r_state != S_IDLE);

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Performs the existing logic and add/sub operations in one cycle.
- Adds signed set-less-than, an iterative shift-add multiplier and an iterative restoring unsigned divider.
- Sits in the EX stage behind a start/done handshake, so the pipeline can stall on busy_o while a multiply or divide is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits (min 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted when start_i && !busy_o.
- data1_i  in  WIDTH  operand A (dividend, multiplicand).
- data2_i  in  WIDTH  operand B (divisor, multiplier).
- ALUCtrl_i  in  3  operation select, sampled at accept.
- data_o  out  WIDTH  registered result.
- Zero_o  out  1  registered; 1 iff data_o == 0.
- busy_o  out  1  iterative op in progress.
- done_o  out  1  one-cycle pulse, result updated this cycle.

Behaviour:
- Reset (async, rst_i=1):
  - data_o=0, Zero_o=1, busy_o=0, done_o=0, state=IDLE, counter=0.
  - Reset mid-operation aborts the op with no done_o.
  - First accept is possible on the first rising edge with rst_i=0.
- ALUCtrl_i encoding (all results truncated to WIDTH bits, mod 2^WIDTH):
  - 000 AND.
  - 001 OR.
  - 010 ADD, carry dropped.
  - 011 SLT: signed A<B gives 1, else 0, zero-extended.
  - 100 MUL: low WIDTH bits of A*B.
  - 101 DIVU: unsigned quotient A/B.
  - 110 SUB: A-B.
  - 111 PASS: result = A.
- Operands and ALUCtrl_i are latched at the accept edge. Input changes after accept do not affect the result.
- FSM states: IDLE, MUL, DIV.
  - IDLE, accept, single-cycle op (000,001,010,011,110,111): at the accept edge, data_o and Zero_o load; done_o=1 for the next cycle; stay IDLE. Latency 1.
  - IDLE, accept, 100: go to MUL, counter=0, busy_o=1. Each edge adds the shifted multiplicand when the current multiplier bit is 1, then counter++. At the edge where counter reaches WIDTH: data_o loads, done_o=1, busy_o=0, return to IDLE. Latency WIDTH edges; busy_o high for exactly WIDTH cycles.
  - IDLE, accept, 101: go to DIV. Restoring divide, one quotient bit per edge, same timing as MUL (WIDTH edges).
- Divide by zero (B==0): quotient = all ones (2^WIDTH-1). Still takes WIDTH cycles; no exception.
- done_o:
  - Exactly one cycle per accepted op.
  - Never asserted without a prior accept.
  - Deasserts the next cycle unless a new single-cycle op was accepted at that edge, in which case it stays high.
- busy_o is low in the done cycle, so start_i may be accepted there (back-to-back issue, no bubble).
- start_i while busy_o=1 is ignored: not queued, no effect on the running op.
- data_o and Zero_o hold their value between done pulses and change only on a done-producing edge.
- Zero_o is computed from the final truncated result (e.g. an ADD overflowing to 0 gives Zero_o=1).

Test Plan:
- Reset: assert rst_i mid-cycle → outputs clear immediately (async); data_o=0, Zero_o=1, busy_o=0, done_o=0. Assert rst_i during MUL at counter=10 → no done_o afterwards; next op runs correctly.
- Single-cycle ops (WIDTH=32), A=0xF0F0_0003, B=0x0FF0_0005, each must give done_o one cycle after accept:
  - AND → 0x00F0_0001; OR → 0xFFF0_0007; ADD → 0x00E0_0008.
  - SUB with A=B=7 → 0, Zero_o=1.
  - SLT with A=0xFFFF_FFFF, B=1 → 1.
  - ADD 0xFFFF_FFFF+1 → 0, Zero_o=1.
- MUL: 0x0001_0003 × 0x0000_0005 → 0x0005_000F. busy_o high exactly 32 cycles, done_o on the 32nd edge after accept. Also 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0001.
- DIVU:
  - 100/7 → 14.
  - 0x8000_0000/2 → 0x4000_0000.
  - 5/0 → 0xFFFF_FFFF, Zero_o=0, still 32 cycles.
  - 3/9 → 0, Zero_o=1.
- Handshake:
  - Hold start_i=1 with MUL, then change operands and ALUCtrl_i during busy → result uses the latched operands; only one done_o.
  - Issue ADD in the done cycle of a DIV → two consecutive done_o cycles with correct results.
- WIDTH=8 build: MUL 0x13×0x11 → 0x43 (low byte), 8-cycle latency. DIVU 200/3 → 66.
